// File: rtl/wishbone_arb_pkg.sv
// Shared types for the N-master Wishbone arbiter.
package wishbone_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef enum logic {
        FIXED = 1'b0,
        RR    = 1'b1
    } arb_mode_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational pick of the first set request bit, searching upward from
// index 'start' and wrapping past N-1 back to 0.
module rr_priority_picker #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] start,
    output logic             valid,
    output logic [PTR_W-1:0] idx
);

    localparam logic [PTR_W:0] N_W = (PTR_W + 1)'(N);

    logic [N-1:0]     rot;
    logic [PTR_W-1:0] off;
    logic [PTR_W:0]   sum;

    // Rotate so the start position lands on bit 0.
    assign rot = N'({req, req} >> start);

    always_comb begin
        valid = 1'b0;
        off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                valid = 1'b1;
                off   = PTR_W'(i);
            end
        end
    end

    assign sum = {1'b0, start} + {1'b0, off};
    assign idx = PTR_W'((sum >= N_W) ? sum - N_W : sum);

endmodule

// File: rtl/wishbone_arbiter.sv
// N-master to 1-slave Wishbone arbiter: fixed or round-robin priority,
// bus lock for the length of the winner's cyc, per-transfer stall timeout.
module wishbone_arbiter
    import wishbone_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ROUND_ROBIN    = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_MASTERS-1:0]  m_cyc,
    input  logic [NUM_MASTERS-1:0]  m_stb,
    input  logic [NUM_MASTERS-1:0]  m_we,
    input  logic [ADDR_WIDTH-1:0]   m_adr   [NUM_MASTERS],
    input  logic [DATA_WIDTH-1:0]   m_dat_w [NUM_MASTERS],
    input  logic [DATA_WIDTH/8-1:0] m_sel   [NUM_MASTERS],
    output logic [NUM_MASTERS-1:0]  m_ack,
    output logic [NUM_MASTERS-1:0]  m_err,
    output logic [DATA_WIDTH-1:0]   m_dat_r,
    output logic                    s_cyc,
    output logic                    s_stb,
    output logic                    s_we,
    output logic [ADDR_WIDTH-1:0]   s_adr,
    output logic [DATA_WIDTH-1:0]   s_dat_w,
    output logic [DATA_WIDTH/8-1:0] s_sel,
    input  logic                    s_ack,
    input  logic                    s_err,
    input  logic [DATA_WIDTH-1:0]   s_dat_r,
    output logic [NUM_MASTERS-1:0]  grant_out
);

    localparam int PTR_W = $clog2(NUM_MASTERS);
    localparam int TO_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_MASTERS - 1);
    localparam arb_mode_e        MODE     = (ROUND_ROBIN != 0) ? RR : FIXED;

    state_t                 state_reg, state_next;
    logic [NUM_MASTERS-1:0] grant_reg, grant_next;
    logic [PTR_W-1:0]       gidx_reg, gidx_next;
    logic [PTR_W-1:0]       rr_ptr_reg, rr_ptr_next;
    logic [TO_W-1:0]        to_cnt_reg, to_cnt_next;

    logic                   busy, timeout_hit, granted_cyc, stall, load;
    logic [NUM_MASTERS-1:0] req;
    logic [PTR_W-1:0]       pick_start, pick_idx;
    logic                   pick_valid;

    assign busy        = (state_reg == BUSY);
    assign timeout_hit = busy && (TIMEOUT_CYCLES != 0) && (to_cnt_reg == TO_LIMIT);
    assign granted_cyc = m_cyc[gidx_reg];
    assign stall       = (TIMEOUT_CYCLES != 0) && s_stb && !s_ack && !s_err;

    // On release the outgoing master is masked so it cannot win straight back.
    assign req        = busy ? (m_cyc & ~grant_reg) : m_cyc;
    assign pick_start = (MODE == RR) ? rr_ptr_reg : '0;

    rr_priority_picker #(
        .N     (NUM_MASTERS),
        .PTR_W (PTR_W)
    ) u_picker (
        .req   (req),
        .start (pick_start),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            gidx_reg   <= '0;
            rr_ptr_reg <= '0;
            to_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            gidx_reg   <= gidx_next;
            rr_ptr_reg <= rr_ptr_next;
            to_cnt_reg <= to_cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        gidx_next   = gidx_reg;
        rr_ptr_next = rr_ptr_reg;
        to_cnt_next = to_cnt_reg;
        load        = 1'b0;
        case (state_reg)
            IDLE: load = pick_valid;
            BUSY: begin
                if (timeout_hit || (!granted_cyc && !pick_valid)) begin
                    state_next  = IDLE;
                    grant_next  = '0;
                    gidx_next   = '0;
                    to_cnt_next = '0;
                end else if (!granted_cyc) begin
                    load = 1'b1;
                end else if (stall) begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end else begin
                    to_cnt_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase
        if (load) begin
            state_next  = BUSY;
            grant_next  = NUM_MASTERS'(1) << pick_idx;
            gidx_next   = pick_idx;
            rr_ptr_next = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
            to_cnt_next = '0;
        end
    end

    // s_cyc follows the registered state only, so m_cyc never reaches it combinationally.
    assign s_cyc     = busy && !timeout_hit;
    assign s_stb     = busy && !timeout_hit && m_stb[gidx_reg];
    assign s_we      = busy && m_we[gidx_reg];
    assign s_adr     = busy ? m_adr[gidx_reg]   : '0;
    assign s_dat_w   = busy ? m_dat_w[gidx_reg] : '0;
    assign s_sel     = busy ? m_sel[gidx_reg]   : '0;
    assign m_dat_r   = busy ? s_dat_r : '0;
    assign grant_out = grant_reg;

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_term
            assign m_ack[gi] = grant_reg[gi] && !timeout_hit && s_ack && !s_err;
            assign m_err[gi] = grant_reg[gi] && (timeout_hit || s_err);
        end
    endgenerate

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Bench: a fixed-priority 2-master and a round-robin 3-master arbiter, each
// checked every cycle against an ownership model, plus directed literal checks.
module tb_wishbone_arbiter;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]  cyc    [2];
    logic [2:0]  stb    [2];
    logic [2:0]  we     [2];
    logic [31:0] adr    [2][3];
    logic [31:0] dat_w  [2][3];
    logic [3:0]  sel    [2][3];
    logic        ack_en [2];
    logic        err_en [2];

    logic [2:0]  grant_mon [2];
    logic [2:0]  ack_mon   [2];
    logic [2:0]  err_mon   [2];
    logic        s_cyc_mon [2];
    logic [31:0] dat_mon   [2];

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    function automatic int pick(input logic [2:0] r, input int n, input int start, input int excl);
        int i;
        for (int k = 0; k < n; k++) begin
            i = (start + k) % n;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic check(input string name, input int inst, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t got=%h want=%h", name, inst, $time, got, want);
        end
    endtask

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_inst
            localparam int N = (gi == 0) ? 2 : 3;

            logic [N-1:0]  m_cyc, m_stb, m_we, m_ack, m_err, grant_out;
            logic [31:0]   m_adr [N];
            logic [31:0]   m_dat_w [N];
            logic [3:0]    m_sel [N];
            logic [31:0]   m_dat_r, s_adr, s_dat_w, s_dat_r;
            logic [3:0]    s_sel;
            logic          s_cyc, s_stb, s_we, s_ack, s_err;

            assign m_cyc = cyc[gi][N-1:0];
            assign m_stb = stb[gi][N-1:0];
            assign m_we  = we[gi][N-1:0];
            for (genvar gj = 0; gj < N; gj++) begin : g_m
                assign m_adr[gj]   = adr[gi][gj];
                assign m_dat_w[gj] = dat_w[gi][gj];
                assign m_sel[gj]   = sel[gi][gj];
            end

            // Zero-wait slave: responds in the same cycle as stb.
            assign s_ack   = s_stb & ack_en[gi];
            assign s_err   = s_stb & err_en[gi];
            assign s_dat_r = s_stb ? slave_data(s_adr) : 32'h0;

            assign grant_mon[gi] = 3'(grant_out);
            assign ack_mon[gi]   = 3'(m_ack);
            assign err_mon[gi]   = 3'(m_err);
            assign s_cyc_mon[gi] = s_cyc;
            assign dat_mon[gi]   = m_dat_r;

            wishbone_arbiter #(
                .NUM_MASTERS    (N),
                .ADDR_WIDTH     (32),
                .DATA_WIDTH     (32),
                .ROUND_ROBIN    (gi),
                .TIMEOUT_CYCLES (TO)
            ) dut (
                .clk       (clk),
                .rst       (rst),
                .m_cyc     (m_cyc),
                .m_stb     (m_stb),
                .m_we      (m_we),
                .m_adr     (m_adr),
                .m_dat_w   (m_dat_w),
                .m_sel     (m_sel),
                .m_ack     (m_ack),
                .m_err     (m_err),
                .m_dat_r   (m_dat_r),
                .s_cyc     (s_cyc),
                .s_stb     (s_stb),
                .s_we      (s_we),
                .s_adr     (s_adr),
                .s_dat_w   (s_dat_w),
                .s_sel     (s_sel),
                .s_ack     (s_ack),
                .s_err     (s_err),
                .s_dat_r   (s_dat_r),
                .grant_out (grant_out)
            );

            // Model: owner index (-1 = free), next round-robin priority, stall length.
            int owner = -1;
            int pri   = 0;
            int stall = 0;
            int nxt;
            bit mbusy, mtmo, e_stb, e_cyc;
            logic [N-1:0] e_grant, e_ack, e_err;
            logic [31:0]  e_adr, e_dat;
            logic [36:0]  e_ctl;

            always @(negedge clk) begin
                mbusy   = (owner >= 0);
                mtmo    = mbusy && (stall == TO);
                e_grant = '0;
                e_ack   = '0;
                e_err   = '0;
                e_stb   = 1'b0;
                e_cyc   = mbusy && !mtmo;
                e_adr   = 32'h0;
                e_dat   = 32'h0;
                e_ctl   = '0;
                if (mbusy) begin
                    e_grant[owner] = 1'b1;
                    e_stb = !mtmo && stb[gi][owner];
                    e_adr = adr[gi][owner];
                    e_ctl = {we[gi][owner], sel[gi][owner], dat_w[gi][owner]};
                    if (e_stb) e_dat = slave_data(adr[gi][owner]);
                    if (mtmo || (e_stb && err_en[gi])) e_err[owner] = 1'b1;
                    else if (e_stb && ack_en[gi])      e_ack[owner] = 1'b1;
                end
                check("grant", gi, 64'(grant_out), 64'(e_grant));
                check("s_cyc", gi, 64'(s_cyc), 64'(e_cyc));
                check("s_stb", gi, 64'(s_stb), 64'(e_stb));
                check("m_ack", gi, 64'(m_ack), 64'(e_ack));
                check("m_err", gi, 64'(m_err), 64'(e_err));
                check("s_adr", gi, 64'(s_adr), 64'(e_adr));
                check("s_ctl", gi, 64'({s_we, s_sel, s_dat_w}), 64'(e_ctl));
                check("m_dat_r", gi, 64'(m_dat_r), 64'(e_dat));

                if (rst) begin
                    owner = -1; pri = 0; stall = 0;
                end else if (!mbusy) begin
                    nxt = pick(cyc[gi], N, (gi == 1) ? pri : 0, -1);
                    if (nxt >= 0) begin owner = nxt; pri = (nxt + 1) % N; end
                    stall = 0;
                end else if (mtmo) begin
                    owner = -1; stall = 0;
                end else if (!cyc[gi][owner]) begin
                    nxt = pick(cyc[gi], N, (gi == 1) ? pri : 0, owner);
                    owner = nxt;
                    if (nxt >= 0) pri = (nxt + 1) % N;
                    stall = 0;
                end else if (e_stb && !ack_en[gi] && !err_en[gi]) begin
                    stall++;
                end else begin
                    stall = 0;
                end
            end
        end
    endgenerate

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc[i] = '0; stb[i] = '0; we[i] = '0; ack_en[i] = 1'b0; err_en[i] = 1'b0;
            for (int j = 0; j < 3; j++) begin
                adr[i][j]   = 32'h0;
                dat_w[i][j] = 32'h1000_0000 * (j + 1) + i;
                sel[i][j]   = 4'(j + 3);
            end
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset grant", 0, 64'(grant_mon[0]), 64'h0);
        check("reset grant", 1, 64'(grant_mon[1]), 64'h0);
        check("reset s_cyc", 1, 64'(s_cyc_mon[1]), 64'h0);
        step();

        // Fixed priority: simultaneous request, then handover.
        adr[0][0] = 32'h200; adr[0][1] = 32'h300; we[0] = 3'b010; ack_en[0] = 1'b1;
        cyc[0] = 3'b011; stb[0] = 3'b011;
        @(negedge clk); check("fx no comb grant", 0, 64'(grant_mon[0]), 64'h0); step();
        @(negedge clk); check("fx m0 wins", 0, 64'(grant_mon[0]), 64'b001);
        check("fx ack m0", 0, 64'(ack_mon[0]), 64'b001); step();
        cyc[0] = 3'b010; stb[0] = 3'b010;
        @(negedge clk); check("fx release cycle", 0, 64'(grant_mon[0]), 64'b001); step();
        @(negedge clk); check("fx handover", 0, 64'(grant_mon[0]), 64'b010);
        check("fx m1 data", 0, 64'(dat_mon[0]), 64'hDEAD_0300); step();
        cyc[0] = '0; stb[0] = '0;
        @(negedge clk); step();
        @(negedge clk); check("fx idle", 0, 64'(grant_mon[0]), 64'h0); step();

        // Simultaneous ack and err: err wins.
        err_en[0] = 1'b1; cyc[0] = 3'b010; stb[0] = 3'b010;
        @(negedge clk); step();
        @(negedge clk); check("ack+err ack", 0, 64'(ack_mon[0]), 64'h0);
        check("ack+err err", 0, 64'(err_mon[0]), 64'b010); step();
        cyc[0] = '0; stb[0] = '0; err_en[0] = 1'b0;
        @(negedge clk); step();
        @(negedge clk); step();

        // Timeout: slave never responds.
        ack_en[0] = 1'b0; cyc[0] = 3'b001; stb[0] = 3'b001;
        @(negedge clk); step();
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk); check("to no err yet", 0, 64'(err_mon[0]), 64'h0);
            check("to s_cyc held", 0, 64'(s_cyc_mon[0]), 64'h1); step();
        end
        @(negedge clk); check("to err pulse", 0, 64'(err_mon[0]), 64'b001);
        check("to s_cyc drop", 0, 64'(s_cyc_mon[0]), 64'h0); step();
        @(negedge clk); check("to idle", 0, 64'(grant_mon[0]), 64'h0);
        check("to err single", 0, 64'(err_mon[0]), 64'h0); step();
        cyc[0] = '0; stb[0] = '0;
        @(negedge clk); check("to recompete", 0, 64'(grant_mon[0]), 64'b001); step();
        @(negedge clk); step();

        // Round-robin, three masters: order 0,1,2,0.
        ack_en[1] = 1'b1; adr[1][0] = 32'h400; adr[1][1] = 32'h410; adr[1][2] = 32'h420;
        cyc[1] = 3'b111; stb[1] = 3'b111;
        @(negedge clk); step();
        @(negedge clk); check("rr first 0", 1, 64'(grant_mon[1]), 64'b001); step();
        cyc[1] = 3'b110; stb[1] = 3'b110;
        @(negedge clk); step();
        cyc[1] = 3'b111; stb[1] = 3'b111;
        @(negedge clk); check("rr then 1", 1, 64'(grant_mon[1]), 64'b010); step();
        cyc[1] = 3'b101; stb[1] = 3'b101;
        @(negedge clk); step();
        cyc[1] = 3'b111; stb[1] = 3'b111;
        @(negedge clk); check("rr then 2", 1, 64'(grant_mon[1]), 64'b100);
        check("rr data m2", 1, 64'(dat_mon[1]), 64'hDEAD_0420); step();
        cyc[1] = 3'b011; stb[1] = 3'b011;
        @(negedge clk); step();
        cyc[1] = 3'b111; stb[1] = 3'b111;
        @(negedge clk); check("rr wrap 0", 1, 64'(grant_mon[1]), 64'b001); step();
        cyc[1] = '0; stb[1] = '0;
        @(negedge clk); step();
        @(negedge clk); step();

        // Lock: master 0 holds cyc over four reads while master 1 waits.
        adr[1][0] = 32'h100; adr[1][1] = 32'h500; cyc[1] = 3'b001; stb[1] = 3'b001;
        @(negedge clk); step();
        cyc[1] = 3'b011; stb[1] = 3'b011;
        for (int k = 0; k < 4; k++) begin
            adr[1][0] = 32'h100 + 32'(4 * k);
            @(negedge clk); check("lock grant", 1, 64'(grant_mon[1]), 64'b001);
            check("lock data", 1, 64'(dat_mon[1]), 64'(32'hDEAD_0100 + 32'(4 * k)));
            check("lock ack", 1, 64'(ack_mon[1]), 64'b001); step();
        end
        cyc[1] = 3'b010; stb[1] = 3'b010;
        @(negedge clk); check("lock release", 1, 64'(grant_mon[1]), 64'b001); step();
        @(negedge clk); check("lock m1 next", 1, 64'(grant_mon[1]), 64'b010); step();
        cyc[1] = '0; stb[1] = '0;
        @(negedge clk); step();
        @(negedge clk); step();

        // Reset mid-transfer with master 1 granted.
        ack_en[1] = 1'b0; cyc[1] = 3'b010; stb[1] = 3'b010;
        @(negedge clk); step();
        @(negedge clk); check("rst pre grant", 1, 64'(grant_mon[1]), 64'b010);
        check("rst pre s_cyc", 1, 64'(s_cyc_mon[1]), 64'h1); step();
        rst = 1'b1;
        @(negedge clk); step();
        rst = 1'b0; cyc[1] = '0; stb[1] = '0; ack_en[1] = 1'b1;
        @(negedge clk); check("rst grant", 1, 64'(grant_mon[1]), 64'h0);
        check("rst s_cyc", 1, 64'(s_cyc_mon[1]), 64'h0);
        check("rst no ack", 1, 64'(ack_mon[1]), 64'h0); step();
        @(negedge clk); check("rst no ack later", 1, 64'(ack_mon[1]), 64'h0); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
